dff_delay_line_param: RTL and testbench

//  Parametrised data delay line: WIDTH-bit, DEPTH-stage D-flip-flop chain with a valid bit per stage.

---
 rtl/dff_delay_line_param_pkg.sv | 45 ++++
 rtl/dff_delay_line_param_if.sv | 30 +++
 rtl/dff_delay_line_param_stage_vld.sv | 28 ++
 rtl/dff_delay_line_param.sv | 89 ++++++++
 tb/tb_dff_delay_line_param.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/dff_delay_line_param_pkg.sv
// Shared definitions for the parametrised delay line: width derivation helpers
// and the per-edge operation encoding (clear beats shift beats hold).
package dff_delay_line_param_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Tap select is at least one bit wide so a single-stage build still has a port.
  function automatic int tap_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return clog2(depth + 1);
  endfunction

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_SHIFT = 2'd1,
    OP_CLEAR = 2'd2
  } stage_op_e;

  // Reset and flush share one clear path; enable only matters when neither is set.
  function automatic stage_op_e decode_op(input logic rst, input logic flush, input logic en);
    stage_op_e op;
    if (rst || flush) begin
      op = OP_CLEAR;
    end else if (en) begin
      op = OP_SHIFT;
    end else begin
      op = OP_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/dff_delay_line_param_if.sv
// Data/control bundle of the delay line; master drives the input word, slave is the line itself.
interface dff_delay_line_param_if
  import dff_delay_line_param_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int TAP_W = tap_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic             i_en;
  logic             i_flush;
  logic             i_valid;
  logic [WIDTH-1:0] i_data;
  logic [TAP_W-1:0] i_tap;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic [CNT_W-1:0] o_vcount;
  logic [WIDTH-1:0] o_last;

  modport master (
    output i_en, i_flush, i_valid, i_data, i_tap,
    input  o_data, o_valid, o_vcount, o_last
  );

  modport slave (
    input  i_en, i_flush, i_valid, i_data, i_tap,
    output o_data, o_valid, o_vcount, o_last
  );
endinterface

// File: rtl/dff_delay_line_param_stage_vld.sv
// One delay stage: WIDTH data flops plus a valid flop, with synchronous clear and load enable.
module dff_stage_vld #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             v,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
);
  logic [WIDTH-1:0] data_reg;
  logic             vld_reg;

  always_ff @(posedge CLK) begin
    if (clr) begin
      data_reg <= '0;
      vld_reg  <= 1'b0;
    end else if (en) begin
      data_reg <= d;
      vld_reg  <= v;
    end
  end

  assign q     = data_reg;
  assign q_vld = vld_reg;
endmodule

// File: rtl/dff_delay_line_param.sv
// WIDTH x DEPTH flop delay line with per-stage valid, stall, flush, a run-time
// output tap (clamped to the last stage) and a registered count of valid stages.
module dff_delay_line_param
  import dff_delay_line_param_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int ZERO_INVALID = 1
) (
  input logic CLK,
  input logic RST,
  dff_delay_line_param_if.slave bus
);
  localparam int TAP_W = tap_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(DEPTH - 1);

  stage_op_e        stage_op;
  logic             stage_clr;
  logic             stage_en;
  logic [WIDTH-1:0] head_data;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_vld;
  logic [TAP_W-1:0] tap_sel;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign stage_op  = decode_op(RST, bus.i_flush, bus.i_en);
  assign stage_clr = (stage_op == OP_CLEAR);
  assign stage_en  = (stage_op == OP_SHIFT);

  // An invalid word is optionally scrubbed so stale data never travels down the line.
  assign head_data = ((ZERO_INVALID != 0) && !bus.i_valid) ? '0 : bus.i_data;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] d_in;
      logic             v_in;
      if (gi == 0) begin : g_head
        assign d_in = head_data;
        assign v_in = bus.i_valid;
      end else begin : g_body
        assign d_in = stage_data[gi-1];
        assign v_in = stage_vld[gi-1];
      end
      dff_stage_vld #(
        .WIDTH (WIDTH)
      ) u_stage (
        .CLK   (CLK),
        .en    (stage_en),
        .clr   (stage_clr),
        .d     (d_in),
        .v     (v_in),
        .q     (stage_data[gi]),
        .q_vld (stage_vld[gi])
      );
    end
  endgenerate

  // A power-of-two depth can address every tap code, so no clamp is needed there.
  generate
    if (DEPTH == (1 << TAP_W)) begin : g_tap_full
      assign tap_sel = bus.i_tap;
    end else begin : g_tap_clamp
      assign tap_sel = (bus.i_tap > LAST_TAP) ? LAST_TAP : bus.i_tap;
    end
  endgenerate

  // Word entering minus word leaving; the difference keeps the count equal to popcount(vld).
  always_comb begin
    count_next = count_reg;
    if (stage_en) begin
      count_next = count_reg + CNT_W'(bus.i_valid) - CNT_W'(stage_vld[DEPTH-1]);
    end
  end

  always_ff @(posedge CLK) begin
    if (stage_clr) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign bus.o_data   = stage_data[tap_sel];
  assign bus.o_valid  = stage_vld[tap_sel];
  assign bus.o_vcount = count_reg;
  assign bus.o_last   = stage_data[DEPTH-1];
endmodule

// File: tb/tb_dff_delay_line_param.sv
// Bench for dff_delay_line_param: a 4-deep zero-scrubbing line and a 3-deep pass-through line
// share one stimulus stream and are compared every cycle against queue models.
module tb_dff_delay_line_param;
  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } ent_t;

  logic       CLK;
  logic       RST;
  logic       flush;
  logic       en;
  logic       valid;
  logic [7:0] data;
  logic [1:0] tap;

  int n_cmp = 0;
  int n_bad = 0;
  bit model_live = 0;

  ent_t mq_a[$];
  ent_t mq_b[$];

  dff_delay_line_param_if #(.WIDTH(8), .DEPTH(4)) bus_a ();
  dff_delay_line_param_if #(.WIDTH(8), .DEPTH(3)) bus_b ();

  assign bus_a.i_en    = en;
  assign bus_a.i_flush = flush;
  assign bus_a.i_valid = valid;
  assign bus_a.i_data  = data;
  assign bus_a.i_tap   = tap;
  assign bus_b.i_en    = en;
  assign bus_b.i_flush = flush;
  assign bus_b.i_valid = valid;
  assign bus_b.i_data  = data;
  assign bus_b.i_tap   = tap;

  dff_delay_line_param #(.WIDTH(8), .DEPTH(4), .ZERO_INVALID(1)) dut_a (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_a)
  );

  dff_delay_line_param #(.WIDTH(8), .DEPTH(3), .ZERO_INVALID(0)) dut_b (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq_a.delete();
    mq_b.delete();
    for (int k = 0; k < 4; k++) mq_a.push_back('0);
    for (int k = 0; k < 3; k++) mq_b.push_back('0);
  endtask

  // Line behaviour at one rising edge, in terms of whole words entering and leaving.
  task automatic model_edge();
    ent_t ea;
    ent_t eb;
    if (RST || flush) begin
      model_clear();
    end else if (en) begin
      ea.v = valid;
      ea.d = valid ? data : 8'h00;
      eb.v = valid;
      eb.d = data;
      mq_a.push_front(ea);
      void'(mq_a.pop_back());
      mq_b.push_front(eb);
      void'(mq_b.pop_back());
    end
  endtask

  task automatic step(input logic r, input logic f, input logic e, input logic v,
                      input logic [7:0] d, input logic [1:0] t);
    RST   = r;
    flush = f;
    en    = e;
    valid = v;
    data  = d;
    tap   = t;
    @(posedge CLK);
    model_edge();
    model_live = 1;
    #1;
  endtask

  always @(negedge CLK) begin : cmp
    int ta;
    int tbi;
    int ca;
    int cb;
    if (model_live) begin
      ta  = (int'(tap) > 3) ? 3 : int'(tap);
      tbi = (int'(tap) > 2) ? 2 : int'(tap);
      ca = 0;
      cb = 0;
      foreach (mq_a[k]) ca += int'(mq_a[k].v);
      foreach (mq_b[k]) cb += int'(mq_b[k].v);
      chk("a_data",   bus_a.o_data,   mq_a[ta].d);
      chk("a_valid",  bus_a.o_valid,  mq_a[ta].v);
      chk("a_vcount", bus_a.o_vcount, ca);
      chk("a_last",   bus_a.o_last,   mq_a[3].d);
      chk("b_data",   bus_b.o_data,   mq_b[tbi].d);
      chk("b_valid",  bus_b.o_valid,  mq_b[tbi].v);
      chk("b_vcount", bus_b.o_vcount, cb);
      chk("b_last",   bus_b.o_last,   mq_b[2].d);
    end
  end

  initial begin
    RST = 1'b1; flush = 1'b0; en = 1'b0; valid = 1'b0; data = 8'h00; tap = 2'd0;

    // Reset dominates an enabled valid input.
    repeat (2) step(1, 0, 1, 1, 8'hFF, 0);
    chk("rst_data",   bus_a.o_data, 8'h00);
    chk("rst_valid",  bus_a.o_valid, 1'b0);
    chk("rst_vcount", bus_a.o_vcount, 0);
    chk("rst_last",   bus_a.o_last, 8'h00);

    // Full-depth latency and count ramp.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 1, 8'(8'h11 * (i + 1)), 3);
      chk("ramp_vcount", bus_a.o_vcount, (i < 4) ? i + 1 : 4);
      if (i == 3) begin
        chk("ramp_data11", bus_a.o_data, 8'h11);
        chk("ramp_valid",  bus_a.o_valid, 1'b1);
        chk("ramp_last11", bus_a.o_last, 8'h11);
      end
    end
    chk("ramp_data22", bus_a.o_data, 8'h22);

    // Tap 0 is one-cycle delay; tap changes act in the same cycle; depth-3 clamps tap 3.
    step(0, 0, 1, 1, 8'hA5, 0);
    chk("tap0_data", bus_a.o_data, 8'hA5);
    tap = 2'd2;
    #1;
    chk("tap2_data", bus_a.o_data, 8'h44);
    tap = 2'd3;
    #1;
    chk("clamp_b", bus_b.o_data, 8'h44);
    chk("tap3_a",  bus_a.o_data, 8'h33);

    // Stall holds everything, then shift resumes.
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 1, 8'(i), 3);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 8'hEE, 3);
      chk("stall_data",   bus_a.o_data, 8'h01);
      chk("stall_vcount", bus_a.o_vcount, 4);
      chk("stall_last",   bus_b.o_last, 8'h02);
    end
    step(0, 0, 1, 1, 8'h05, 3);
    chk("resume_last", bus_a.o_last, 8'h02);

    // Flush drops the word presented with it; reset with flush is the same.
    step(0, 1, 1, 1, 8'h77, 0);
    chk("flush_vcount", bus_a.o_vcount, 0);
    chk("flush_data",   bus_a.o_data, 8'h00);
    chk("flush_last",   bus_a.o_last, 8'h00);
    step(0, 0, 1, 1, 8'h31, 0);
    step(0, 0, 1, 1, 8'h32, 0);
    step(1, 1, 1, 1, 8'h33, 0);
    chk("rstfl_vcount", bus_a.o_vcount, 0);
    chk("rstfl_data",   bus_a.o_data, 8'h00);

    // Alternating valid: scrubbed vs pass-through invalid stages.
    for (int i = 0; i < 8; i++) step(0, 0, 1, (i % 2) == 0, 8'h5A, 0);
    chk("alt_a_data",   bus_a.o_data, 8'h00);
    chk("alt_a_valid",  bus_a.o_valid, 1'b0);
    chk("alt_a_vcount", bus_a.o_vcount, 2);
    chk("alt_a_last",   bus_a.o_last, 8'h5A);
    chk("alt_b_data",   bus_b.o_data, 8'h5A);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(15) == 0), ($urandom_range(3) != 0),
           1'($urandom), 8'($urandom), 2'($urandom));
      tap = 2'($urandom);
      #1;
    end

    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
